input_debouncer: RTL and testbench

- Sequential front-end stage that conditions a raw, asynchronous, possibly bouncing single-bit input (switch, button, external pin) before it reaches the gate primitives.
- Synchronizes the input into the `clk` domain and filters it with a counter-based stability check.
- Drives a clean level `b` that feeds a gate input directly, plus optional one-cycle rise/fall pulses.

---
 rtl/input_debouncer.sv | 125 ++++++++++++
 tb/tb_input_debouncer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronizes a raw asynchronous input and qualifies level changes with a stability counter.
// Optional macro DEBOUNCE_EDGE_EN compiles in the registered rise/fall pulse outputs.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic b,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES);
  localparam logic SINGLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam state_t RST_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_b;
  logic                   r_busy;

  logic          w_s;
  logic          w_diff;
  logic          w_is_wait;
  logic          w_commit;
  logic [CW-1:0] w_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], a};
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_diff    = (w_s != r_b);
  assign w_is_wait = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);
  assign w_cnt_inc = r_cnt + CW'(1);
  // A single-cycle qualification commits straight from IDLE without a WAIT visit.
  assign w_commit  = w_diff && (w_is_wait ? (w_cnt_inc == CNT_LAST) : SINGLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_b     <= RESET_LEVEL;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE_LOW, IDLE_HIGH: begin
          if (w_diff) begin
            if (w_commit) begin
              r_b     <= w_s;
              r_state <= w_s ? IDLE_HIGH : IDLE_LOW;
            end else begin
              r_state <= w_s ? WAIT_HIGH : WAIT_LOW;
              r_cnt   <= CW'(1);
              r_busy  <= 1'b1;
            end
          end
        end
        WAIT_HIGH, WAIT_LOW: begin
          if (!w_diff) begin
            r_state <= r_b ? IDLE_HIGH : IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_commit) begin
            r_b     <= w_s;
            r_state <= w_s ? IDLE_HIGH : IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= RST_STATE;
          r_cnt   <= '0;
          r_b     <= RESET_LEVEL;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign b    = r_b;
  assign busy = r_busy;

`ifdef DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_commit && w_s;
      r_fall <= w_commit && !w_s;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: run-length reference model compared every cycle, plus directed timing checks.
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_EN
  localparam int EDGE_EN = 1;
`else
  localparam int EDGE_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic a;
  logic b0, rise0, fall0, busy0;
  logic b1, rise1, fall1, busy1;

  always #5 clk = ~clk;

  input_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  input_debouncer #(.STABLE_CYCLES(1), .SYNC_STAGES(3), .RESET_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Reference model: a delay line for the synchronizer and a run length of disagreeing samples.
  logic [7:0]  m_q    [2];
  int unsigned m_run  [2];
  logic        m_b    [2];
  logic        m_rise [2];
  logic        m_fall [2];
  logic        m_busy [2];

  task automatic model_reset(input int unsigned i, input logic rl);
    m_q[i]    = {8{rl}};
    m_run[i]  = 0;
    m_b[i]    = rl;
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    m_busy[i] = 1'b0;
  endtask

  task automatic model_step(input int unsigned i, input int unsigned stable,
                            input int unsigned sync, input logic ain);
    logic s_seen;
    s_seen    = m_q[i][sync-1];
    m_q[i]    = {m_q[i][6:0], ain};
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (s_seen != m_b[i]) begin
      m_run[i]++;
      if (m_run[i] == stable) begin
        m_b[i]    = s_seen;
        m_run[i]  = 0;
        m_rise[i] = s_seen;
        m_fall[i] = !s_seen;
      end
    end else begin
      m_run[i] = 0;
    end
    m_busy[i] = (m_run[i] != 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0, 1'b0);
      model_reset(1, 1'b1);
    end else begin
      model_step(0, 4, 2, a);
      model_step(1, 1, 3, a);
    end
  end

  // Edge counter, per-cycle compare and event log for the directed checks on instance 0.
  int   cyc = 0;
  int   b_chg_cyc = 0, busy_on_cyc = 0, busy_off_cyc = 0;
  int   rise_cnt = 0, fall_cnt = 0, busy_cnt = 0;
  logic prev_b0 = 1'b0, prev_busy0 = 1'b0;
  logic pe;

  always @(posedge clk) begin
    cyc++;
    #1;
    pe = (EDGE_EN != 0);
    chk1("b0", b0, m_b[0]);
    chk1("busy0", busy0, m_busy[0]);
    chk1("rise0", rise0, m_rise[0] & pe);
    chk1("fall0", fall0, m_fall[0] & pe);
    chk1("b1", b1, m_b[1]);
    chk1("busy1", busy1, m_busy[1]);
    chk1("rise1", rise1, m_rise[1] & pe);
    chk1("fall1", fall1, m_fall[1] & pe);
    if (b0 !== prev_b0) b_chg_cyc = cyc;
    if (busy0 && !prev_busy0) busy_on_cyc = cyc;
    if (!busy0 && prev_busy0) busy_off_cyc = cyc;
    if (rise0) rise_cnt++;
    if (fall0) fall_cnt++;
    if (busy0) busy_cnt++;
    prev_b0    = b0;
    prev_busy0 = busy0;
  end

  int k, r0, f0, bc0;

  initial begin
    rst_n = 1'b0;
    a     = 1'b1;

    // Reset held with the input high
    repeat (3) @(negedge clk);
    chk1("s1_reset_b0", b0, 1'b0);
    chk1("s1_reset_rise0", rise0, 1'b0);
    chk1("s1_reset_fall0", fall0, 1'b0);
    chk1("s1_reset_busy0", busy0, 1'b0);
    chk1("s1_reset_b1", b1, 1'b1);

    rst_n = 1'b1;
    k  = cyc + 1;
    r0 = rise_cnt;
    repeat (10) @(negedge clk);
    chk("s1_b_edge", b_chg_cyc, k + 5);
    chk("s1_rise_count", rise_cnt - r0, EDGE_EN);
    chk1("s1_b_final", b0, 1'b1);

    // Clean fall
    a  = 1'b0;
    k  = cyc + 1;
    f0 = fall_cnt;
    repeat (10) @(negedge clk);
    chk("s2_busy_on", busy_on_cyc, k + 2);
    chk("s2_b_edge", b_chg_cyc, k + 5);
    chk("s2_busy_off", busy_off_cyc, k + 5);
    chk("s2_fall_count", fall_cnt - f0, EDGE_EN);
    chk1("s2_b_final", b0, 1'b0);

    // Bounce 1,0,1 then hold high
    r0 = rise_cnt;
    f0 = fall_cnt;
    a  = 1'b1;
    @(negedge clk);
    a  = 1'b0;
    @(negedge clk);
    a  = 1'b1;
    k  = cyc + 1;
    repeat (10) @(negedge clk);
    chk("s3_b_edge", b_chg_cyc, k + 5);
    chk("s3_busy_on", busy_on_cyc, k + 2);
    chk("s3_rise_count", rise_cnt - r0, EDGE_EN);
    chk("s3_fall_count", fall_cnt - f0, 0);

    a = 1'b0;
    repeat (10) @(negedge clk);

    // Three-cycle glitch is rejected
    r0  = rise_cnt;
    bc0 = busy_cnt;
    a   = 1'b1;
    repeat (3) @(negedge clk);
    a   = 1'b0;
    repeat (10) @(negedge clk);
    chk("s4_glitch_busy_cycles", busy_cnt - bc0, 3);
    chk("s4_glitch_rise_count", rise_cnt - r0, 0);
    chk1("s4_glitch_b", b0, 1'b0);

    // Four-cycle pulse propagates
    r0 = rise_cnt;
    f0 = fall_cnt;
    a  = 1'b1;
    k  = cyc + 1;
    repeat (4) @(negedge clk);
    a  = 1'b0;
    repeat (4) @(negedge clk);
    chk1("s4_pulse_b_high", b0, 1'b1);
    chk("s4_pulse_b_edge", b_chg_cyc, k + 5);
    repeat (8) @(negedge clk);
    chk("s4_pulse_rise_count", rise_cnt - r0, EDGE_EN);
    chk("s4_pulse_fall_count", fall_cnt - f0, EDGE_EN);
    chk1("s4_pulse_b_final", b0, 1'b0);

    // Asynchronous reset while qualifying
    a = 1'b1;
    repeat (3) @(negedge clk);
    chk1("s5_busy_before", busy0, 1'b1);
    #2;
    rst_n = 1'b0;
    a     = 1'b0;
    #1;
    chk1("s5_busy_async", busy0, 1'b0);
    chk1("s5_b_async", b0, 1'b0);
    chk1("s5_b1_async", b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rise_cnt;
    f0 = fall_cnt;
    repeat (10) @(negedge clk);
    chk("s5_rise_count", rise_cnt - r0, 0);
    chk("s5_fall_count", fall_cnt - f0, 0);
    chk1("s5_b_final", b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
